// File: rtl/pci_arb_pkg.sv
// ---------------------------------------------------------------------------
// pci_arb_pkg
// Shared types and constants for the central PCI round-robin arbiter.
//   arb_state_t      : arbiter FSM state (GAP = all GNT# high, GNT = one owner)
//   MAX_REQ          : largest number of requesters the arbiter supports
//   DEF_IDLE_TIMEOUT : default idle-grant timeout in bus clocks
//   owner_t          : requester index type
//   rr_wrap()        : (base + offset) modulo n, for pointer arithmetic
// ---------------------------------------------------------------------------
package pci_arb_pkg;

  typedef enum logic {GAP, GNT} arb_state_t;

  localparam int MAX_REQ          = 4;
  localparam int DEF_IDLE_TIMEOUT = 16;

  typedef logic [$clog2(MAX_REQ)-1:0] owner_t;

  // Offsets never exceed n, so a single conditional subtract is enough.
  function automatic owner_t rr_wrap(input owner_t base, input int offset, input int n);
    int sum;
    sum = int'(base) + offset;
    if (sum >= n) sum = sum - n;
    return owner_t'(sum);
  endfunction

endpackage

// File: rtl/pci_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// pci_rr_arbiter_if
// Bus-side signal bundle between the PCI masters/backplane and the arbiter.
//   arb_en      : 1 = arbitrate, 0 = park all GNT# high after the current GAP
//   pci_req_n   : raw REQ# pins, active-low, one per requester
//   pci_frame_n : raw FRAME# pin
//   pci_irdy_n  : raw IRDY# pin
//   pci_gnt_n   : registered GNT#, active-low, at most one bit low
//   owner       : index of the current or last grantee
//   owner_vld   : 1 while a GNT# bit is low
//   bus_idle    : registered FRAME# and IRDY# both high
// Modports: master = backplane/masters side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface pci_rr_arbiter_if import pci_arb_pkg::*; #(
  parameter int NUM_REQ = 4
) ();

  logic               arb_en;
  logic [NUM_REQ-1:0] pci_req_n;
  logic               pci_frame_n;
  logic               pci_irdy_n;
  logic [NUM_REQ-1:0] pci_gnt_n;
  owner_t             owner;
  logic               owner_vld;
  logic               bus_idle;

  modport master (
    output arb_en, pci_req_n, pci_frame_n, pci_irdy_n,
    input  pci_gnt_n, owner, owner_vld, bus_idle
  );

  modport slave (
    input  arb_en, pci_req_n, pci_frame_n, pci_irdy_n,
    output pci_gnt_n, owner, owner_vld, bus_idle
  );

endinterface

// File: rtl/pci_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// pci_arb_rr_pick
// Combinational round-robin picker. Scans the pending vector starting at ptr
// and moving upward, wrapping at NUM_REQ.
//   req : pending requests, active-high, NUM_REQ bits
//   ptr : index at which the scan starts
//   idx : first pending index found (ptr when nothing is pending)
//   any : 1 when at least one request is pending
// ---------------------------------------------------------------------------
module pci_arb_rr_pick import pci_arb_pkg::*; #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  owner_t             ptr,
  output owner_t             idx,
  output logic               any
);

  owner_t cand;

  // Outer loop walks scan priority, inner loop matches the candidate index
  // against constant bit positions so no variable bit-select is needed.
  always_comb begin
    idx  = ptr;
    any  = 1'b0;
    cand = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_wrap(ptr, k, NUM_REQ);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any && req[i] && (owner_t'(i) == cand)) begin
          idx = owner_t'(i);
          any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pci_rr_arbiter.sv
// ---------------------------------------------------------------------------
// pci_rr_arbiter
// Central PCI bus arbiter for up to four masters: round-robin fairness, bus
// parking, idle-grant timeout and one all-high GNT# cycle between owners.
// REQ#, FRAME# and IRDY# are registered once; GNT# reacts 2 clocks after REQ#.
//   pci_clk : PCI clock, rising edge only
//   pci_rst : synchronous reset, active-high
//   bus     : pci_rr_arbiter_if.slave (arb_en, REQ#/FRAME#/IRDY# in;
//             GNT#, owner, owner_vld, bus_idle out)
// Parameters: NUM_REQ (2..4), PARK_ID, IDLE_TIMEOUT.
// Optional build macro: PCI_ARB_HOSTPRIO_EN - requester 0 wins every GAP pick
// it takes part in; undefined gives pure round-robin.
// ---------------------------------------------------------------------------
module pci_rr_arbiter import pci_arb_pkg::*; #(
  parameter int NUM_REQ      = 4,
  parameter int PARK_ID      = 0,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input logic              pci_clk,
  input logic              pci_rst,
  pci_rr_arbiter_if.slave  bus
);

  localparam int     CNT_W = $clog2(IDLE_TIMEOUT + 1);
  localparam owner_t PARK  = owner_t'(PARK_ID);

  logic [NUM_REQ-1:0] req_q;
  logic               frame_q;
  logic               irdy_q;
  arb_state_t         state_q, state_d;
  owner_t             owner_q, owner_d;
  owner_t             rr_ptr_q, rr_ptr_d;
  logic               started_q, started_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [NUM_REQ-1:0] gnt_n_q, gnt_n_d;
  logic               owner_vld_q;

  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] others;
  logic               owner_pend;
  logic               other_any;
  logic               bus_idle_q;
  owner_t             pick_idx;
  logic               pick_any;
  logic               idle_inc;
  logic               timeout;
  logic               release_gnt;

  assign pend       = ~req_q;
  assign bus_idle_q = frame_q & irdy_q;
  assign other_any  = |others;

  pci_arb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (pend),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Split pending requests into the owner's own request and everybody else.
  always_comb begin
    others     = '0;
    owner_pend = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_t'(i) == owner_q) owner_pend = pend[i];
      else                        others[i]  = pend[i];
    end
  end

  // Next-state logic. The GNT# vector is derived from the next state so the
  // pins come straight from flops and reflect the decision one clock later.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    started_d   = started_q;
    idle_cnt_d  = idle_cnt_q;
    idle_inc    = 1'b0;
    timeout     = 1'b0;
    release_gnt = 1'b0;
    case (state_q)
      GAP: begin
        // With nothing pending owner_d keeps the last owner: bus parking.
        if (bus.arb_en) begin
          state_d = GNT;
`ifdef PCI_ARB_HOSTPRIO_EN
          if (pend[0])       owner_d = '0;
          else if (pick_any) owner_d = pick_idx;
`else
          if (pick_any)      owner_d = pick_idx;
`endif
        end
      end
      GNT: begin
        // A pending req 0 already counts as "another request", so host
        // priority needs nothing extra here to force the release.
        idle_inc    = bus_idle_q && !started_q && other_any;
        timeout     = idle_inc && (idle_cnt_q == CNT_W'(IDLE_TIMEOUT - 1));
        release_gnt = (other_any && started_q) || timeout ||
                      (!owner_pend && other_any) || !bus.arb_en;
        if (release_gnt) begin
          state_d    = GAP;
          rr_ptr_d   = rr_wrap(owner_q, 1, NUM_REQ);
          started_d  = 1'b0;
          idle_cnt_d = '0;
        end else begin
          if (!frame_q) started_d = 1'b1;
          idle_cnt_d = idle_inc ? idle_cnt_q + CNT_W'(1) : '0;
        end
      end
      default: state_d = GAP;
    endcase
  end

  always_comb begin
    gnt_n_d = '1;
    if (state_d == GNT) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (owner_t'(i) == owner_d) gnt_n_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge pci_clk) begin
    if (pci_rst) begin
      req_q       <= '1;
      frame_q     <= 1'b1;
      irdy_q      <= 1'b1;
      state_q     <= GAP;
      owner_q     <= PARK;
      rr_ptr_q    <= PARK;
      started_q   <= 1'b0;
      idle_cnt_q  <= '0;
      gnt_n_q     <= '1;
      owner_vld_q <= 1'b0;
    end else begin
      req_q       <= bus.pci_req_n;
      frame_q     <= bus.pci_frame_n;
      irdy_q      <= bus.pci_irdy_n;
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      started_q   <= started_d;
      idle_cnt_q  <= idle_cnt_d;
      gnt_n_q     <= gnt_n_d;
      owner_vld_q <= (state_d == GNT);
    end
  end

  assign bus.pci_gnt_n = gnt_n_q;
  assign bus.owner     = owner_q;
  assign bus.owner_vld = owner_vld_q;
  assign bus.bus_idle  = bus_idle_q;

endmodule
